multicycle_cpu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit core. It keeps the 16-bit instruction format, with opcode[15:12], rd[11:8], rs[7:4] and addr8/imm8[7:0]. Execution is sequenced by an FSM, and instruction and data memories are external, reached through valid/ready handshakes so that wait-state memories can be attached. It is the top-level CPU block, and the single-cycle top is retired in its favour.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/mc_alu.sv | 31 +++
 rtl/multicycle_cpu.sv | 168 ++++++++++++++++
 tb/tb_multicycle_cpu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM state encoding,
// instruction field positions and small opcode classification helpers.
package cpu_pkg;

  // Opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // FSM state encoding kept as plain constants for compatibility with older tools
  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_MEM   = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  // Instruction field slice positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // True for opcodes that update the Z flag
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_ADDI);
  endfunction

  // True for every opcode the core defines; the rest are flagged illegal
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_LDI) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle CPU. The caller chooses the b
// operand (register, sign-extended or zero-extended immediate); LDI simply
// passes b through so that all register write-back comes from one place.
module mc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Select the operation; unused opcodes produce zero
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_LDI:          result = b;
      default:         result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction CPU. An FSM steps FETCH -> EXEC -> (MEM)
// and talks to external instruction/data memories through req/ready
// handshakes. Request outputs are registered so address, write enable and
// write data stay frozen while a slow memory holds ready low.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] current_pc,
  output logic [15:0]       instruction,
  output logic [DATA_W-1:0] alu_result,
  output logic              retire,
  output logic              illegal_op,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] reg_file [16];
  logic              z_flag;

  logic [3:0]        opcode;
  logic [3:0]        rd_idx;
  logic [3:0]        rs_idx;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic [ADDR_W-1:0] addr_ext;
  logic [ADDR_W-1:0] pc_inc;

  assign opcode   = ir[OPC_HI:OPC_LO];
  assign rd_idx   = ir[RD_HI:RD_LO];
  assign rs_idx   = ir[RS_HI:RS_LO];
  assign imm8     = ir[IMM_HI:IMM_LO];
  assign rd_val   = reg_file[rd_idx];
  assign rs_val   = reg_file[rs_idx];
  assign addr_ext = ADDR_W'(imm8);
  assign pc_inc   = pc + ADDR_W'(1);

  // Second ALU operand: ADDI sign-extends its immediate, LDI zero-extends it
  always_comb begin
    alu_b = rs_val;
    if (opcode == OP_ADDI)
      alu_b = DATA_W'($signed(imm8));
    else if (opcode == OP_LDI)
      alu_b = DATA_W'(imm8);
  end

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_out),
    .zero   (alu_zero)
  );

  assign imem_addr   = pc;
  assign current_pc  = pc;
  assign instruction = ir;
  assign alu_result  = alu_out;

  // Instruction sequencer: fetch, execute, optional data access, halt
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      z_flag     <= 1'b0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
      retire     <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 16; i++) reg_file[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_FETCH: begin
          // After reset the request is raised here; afterwards it is
          // already high on entry because the previous instruction set it.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
              reg_file[rd_idx] <= alu_out;
              if (op_is_alu(opcode)) z_flag <= alu_zero;
              pc       <= pc_inc;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            OP_LD, OP_ST: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (opcode == OP_ST);
              dmem_addr  <= addr_ext;
              dmem_wdata <= rd_val;
              state      <= ST_MEM;
            end
            OP_JMP, OP_JZ: begin
              if (opcode == OP_JMP || z_flag) pc <= addr_ext;
              else                            pc <= pc_inc;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            OP_HALT: begin
              retire <= 1'b1;
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              if (!op_is_legal(opcode)) illegal_op <= 1'b1;
              pc       <= pc_inc;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          endcase
        end

        ST_MEM: begin
          if (dmem_req && dmem_ready) begin
            if (!dmem_we) reg_file[rd_idx] <= dmem_rdata;
            dmem_req <= 1'b0;
            pc       <= pc_inc;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end

        default: begin
          // Halted: nothing moves until reset
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Testbench for multicycle_cpu (DATA_W=16, ADDR_W=8). Memories with random
// or fixed wait states answer the handshakes; an instruction-level model
// steps once per retire pulse and predicts PC, IR, registers, flags, data
// accesses and the cycle count each instruction should take.
module tb_multicycle_cpu;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ready = 1'b0;
  logic [AW-1:0] current_pc;
  logic [15:0]   instruction;
  logic [DW-1:0] alu_result;
  logic          retire;
  logic          illegal_op;
  logic          halted;

  always #5 clk = ~clk;

  multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .current_pc  (current_pc),
    .instruction (instruction),
    .alu_result  (alu_result),
    .retire      (retire),
    .illegal_op  (illegal_op),
    .halted      (halted)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory contents seen by the responders
  logic [15:0]   imem_arr [256];
  logic [DW-1:0] dmem_arr [256];

  // Reference model state
  int m_pc;
  int m_reg [16];
  int m_dmem [256];
  bit m_z, m_ill, m_halt;
  localparam int MASK = (1 << DW) - 1;

  // Responder bookkeeping
  bit            i_busy, d_busy;
  int            i_left, d_left, last_iwait, last_dwait, i_req_cnt, d_req_cnt;
  int            i_fix = 0;
  int            d_fix = 0;
  logic [AW-1:0] i_addr_cap, d_addr_cap;
  logic          d_we_cap;
  logic [DW-1:0] d_wdata_cap;

  int cyc = 0;
  int last_ret_cyc = 0;
  bit first_ret = 1'b1;
  int retired = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pickWait(input int fix);
    return (fix < 0) ? int'($urandom_range(3, 0)) : fix;
  endfunction

  task automatic modelReset();
    m_pc = 0;
    m_z = 1'b0;
    m_ill = 1'b0;
    m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    i_busy = 1'b0;
    d_busy = 1'b0;
    first_ret = 1'b1;
  endtask

  // Execute one instruction in the model and compare the architectural state
  task automatic modelStep();
    logic [15:0] ins;
    int op, rd, rs, imm, res, sext, expgap;
    ins = imem_arr[m_pc];
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:8]);
    rs  = int'(ins[7:4]);
    imm = int'(ins[7:0]);
    expgap = 2 + last_iwait + ((op == 6 || op == 7) ? 1 + last_dwait : 0);
    checkOutput("fetch_req_cycles", 32'(i_req_cnt), 32'(last_iwait + 1));
    if (!first_ret) checkOutput("retire_gap", 32'(cyc - last_ret_cyc), 32'(expgap));
    first_ret = 1'b0;
    last_ret_cyc = cyc;
    if (op == 6 || op == 7) begin
      checkOutput("dmem_addr", 32'(d_addr_cap), 32'(imm));
      checkOutput("dmem_we", 32'(d_we_cap), 32'(op == 7));
      checkOutput("dmem_req_cycles", 32'(d_req_cnt), 32'(last_dwait + 1));
      if (op == 7) checkOutput("dmem_wdata", 32'(d_wdata_cap), 32'(m_reg[rd]));
    end
    case (op)
      1, 2, 3, 4, 5: begin
        if (imm > 127) sext = imm - 256;
        else           sext = imm;
        case (op)
          1:       res = m_reg[rd] + m_reg[rs];
          2:       res = m_reg[rd] - m_reg[rs];
          3:       res = m_reg[rd] & m_reg[rs];
          4:       res = m_reg[rd] | m_reg[rs];
          default: res = m_reg[rd] + sext;
        endcase
        res = res & MASK;
        m_reg[rd] = res;
        m_z = (res == 0);
        m_pc = (m_pc + 1) % 256;
      end
      6:  begin m_reg[rd] = m_dmem[imm]; m_pc = (m_pc + 1) % 256; end
      7:  begin m_dmem[imm] = m_reg[rd]; m_pc = (m_pc + 1) % 256; end
      8:  m_pc = imm;
      9:  m_pc = m_z ? imm : (m_pc + 1) % 256;
      12: begin m_reg[rd] = imm; m_pc = (m_pc + 1) % 256; end
      15: m_halt = 1'b1;
      0:  m_pc = (m_pc + 1) % 256;
      default: begin m_ill = 1'b1; m_pc = (m_pc + 1) % 256; end
    endcase
    checkOutput("pc", 32'(current_pc), 32'(m_pc));
    checkOutput("ir", 32'(instruction), 32'(ins));
    checkOutput("reg_rd", 32'(dut.reg_file[rd]), 32'(m_reg[rd]));
    checkOutput("z_flag", 32'(dut.z_flag), 32'(m_z));
    checkOutput("illegal_op", 32'(illegal_op), 32'(m_ill));
    checkOutput("halted", 32'(halted), 32'(m_halt));
  endtask

  // Handshake invariants and retire-driven model checks
  task automatic monitor();
    if (imem_req || dmem_req) checkOutput("req_exclusive", 32'(imem_req & dmem_req), 0);
    if (i_busy && imem_req) checkOutput("imem_addr_hold", 32'(imem_addr), 32'(i_addr_cap));
    if (d_busy && dmem_req) begin
      checkOutput("dmem_addr_hold", 32'(dmem_addr), 32'(d_addr_cap));
      checkOutput("dmem_we_hold", 32'(dmem_we), 32'(d_we_cap));
      checkOutput("dmem_wdata_hold", 32'(dmem_wdata), 32'(d_wdata_cap));
    end
    if (retire) begin
      retired++;
      modelStep();
    end
  endtask

  // Memory responders: wait states, then ready with data; junk otherwise
  task automatic drive();
    if (imem_req) begin
      if (!i_busy) begin
        i_busy = 1'b1;
        i_left = pickWait(i_fix);
        last_iwait = i_left;
        i_req_cnt = 0;
        i_addr_cap = imem_addr;
      end
      i_req_cnt++;
      if (i_left == 0) begin
        imem_ready = 1'b1;
        imem_rdata = imem_arr[imem_addr];
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 16'($urandom);
        i_left--;
      end
    end else begin
      i_busy = 1'b0;
      imem_ready = 1'($urandom);
      imem_rdata = 16'($urandom);
    end
    if (dmem_req) begin
      if (!d_busy) begin
        d_busy = 1'b1;
        d_left = pickWait(d_fix);
        last_dwait = d_left;
        d_req_cnt = 0;
        d_addr_cap = dmem_addr;
        d_we_cap = dmem_we;
        d_wdata_cap = dmem_wdata;
      end
      d_req_cnt++;
      if (d_left == 0) begin
        dmem_ready = 1'b1;
        if (dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
        dmem_rdata = dmem_arr[dmem_addr];
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = DW'($urandom);
        d_left--;
      end
    end else begin
      d_busy = 1'b0;
      dmem_ready = 1'($urandom);
      dmem_rdata = DW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    drive();
  endtask

  task automatic doReset();
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", 32'(current_pc), 0);
    checkOutput("rst_ir", 32'(instruction), 0);
    checkOutput("rst_retire", 32'(retire), 0);
    checkOutput("rst_imem_req", 32'(imem_req), 0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 0);
    checkOutput("rst_dmem_we", 32'(dmem_we), 0);
    checkOutput("rst_flags", 32'({illegal_op, halted, dut.z_flag}), 0);
    checkOutput("rst_r1", 32'(dut.reg_file[1]), 0);
    reset = 1'b1;
    modelReset();
    tick();
    checkOutput("req_rise", 32'(imem_req), 1);
    checkOutput("first_fetch_addr", 32'(imem_addr), 0);
  endtask

  // Run until n instructions retire, the model halts, or the budget expires
  task automatic applyStimulus(input int n, input int budget);
    int start;
    int c;
    start = retired;
    c = 0;
    while ((retired - start) < n && !m_halt) begin
      tick();
      c++;
      if (c > budget) begin
        checkOutput("timeout", 32'(retired - start), 32'(n));
        break;
      end
    end
  endtask

  task automatic syncDmemModel();
    for (int i = 0; i < 256; i++) m_dmem[i] = int'(dmem_arr[i]);
  endtask

  task automatic loadDirected();
    for (int i = 0; i < 256; i++) imem_arr[i] = 16'h0000;
    imem_arr[8'h00] = 16'hC105;  // LDI r1,0x05
    imem_arr[8'h01] = 16'hC203;  // LDI r2,0x03
    imem_arr[8'h02] = 16'h1120;  // ADD r1,r2
    imem_arr[8'h03] = 16'h7140;  // ST r1,[0x40]
    imem_arr[8'h04] = 16'h6340;  // LD r3,[0x40]
    imem_arr[8'h05] = 16'h2440;  // SUB r4,r4
    imem_arr[8'h06] = 16'h9020;  // JZ 0x20 (taken)
    imem_arr[8'h20] = 16'h1330;  // ADD r3,r3
    imem_arr[8'h21] = 16'h9040;  // JZ 0x40 (not taken)
    imem_arr[8'h22] = 16'hC501;  // LDI r5,0x01
    imem_arr[8'h23] = 16'h55FF;  // ADDI r5,0xFF
    imem_arr[8'h24] = 16'hC6F0;  // LDI r6,0xF0
    imem_arr[8'h25] = 16'hE000;  // undefined opcode
    imem_arr[8'h26] = 16'hF000;  // HALT
    for (int i = 0; i < 256; i++) dmem_arr[i] = DW'($urandom);
    syncDmemModel();
  endtask

  task automatic loadRandom();
    int ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 12, 1, 5};
    int op;
    for (int i = 0; i < 256; i++) begin
      op = ops[$urandom_range(13, 0)];
      if ($urandom_range(39, 0) == 0) op = 10 + 4 * int'($urandom_range(1, 0));
      imem_arr[i] = {4'(op), 12'($urandom)};
      dmem_arr[i] = DW'($urandom);
    end
    syncDmemModel();
  endtask

  task automatic checkHaltQuiet();
    repeat (6) begin
      tick();
      checkOutput("halt_imem_req", 32'(imem_req), 0);
      checkOutput("halt_dmem_req", 32'(dmem_req), 0);
      checkOutput("halt_retire", 32'(retire), 0);
      checkOutput("halt_flag", 32'(halted), 1);
    end
  endtask

  // Abort a pending load with reset and make sure fetching restarts at 0
  task automatic resetAbort();
    int c;
    for (int i = 0; i < 256; i++) imem_arr[i] = 16'h0000;
    imem_arr[0] = 16'hC1AA;  // LDI r1,0xAA
    imem_arr[1] = 16'h6250;  // LD r2,[0x50]
    syncDmemModel();
    i_fix = 0;
    d_fix = 10;
    doReset();
    applyStimulus(1, 50);
    c = 0;
    while (!dmem_req && c < 20) begin tick(); c++; end
    checkOutput("abort_req_seen", 32'(dmem_req), 1);
    tick();
    tick();
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("abort_dmem_req", 32'(dmem_req), 0);
    checkOutput("abort_pc", 32'(current_pc), 0);
    checkOutput("abort_r1", 32'(dut.reg_file[1]), 0);
    reset = 1'b1;
    modelReset();
    d_fix = 0;
    tick();
    checkOutput("abort_req_rise", 32'(imem_req), 1);
    checkOutput("abort_fetch_addr", 32'(imem_addr), 0);
    applyStimulus(2, 50);
  endtask

  initial begin
    $display("[TB] multicycle_cpu bench start");

    // Directed program, zero-wait fetch, 3-cycle data waits
    loadDirected();
    i_fix = 0;
    d_fix = 3;
    doReset();
    applyStimulus(20, 300);
    checkOutput("dir_r1", 32'(dut.reg_file[1]), 32'h0008);
    checkOutput("dir_r3", 32'(dut.reg_file[3]), 32'h0010);
    checkOutput("dir_r5", 32'(dut.reg_file[5]), 32'h0000);
    checkOutput("dir_r6", 32'(dut.reg_file[6]), 32'h00F0);
    checkOutput("dir_pc", 32'(current_pc), 32'h26);
    checkOutput("dir_illegal", 32'(illegal_op), 1);
    checkHaltQuiet();

    // Same program, instruction memory stalls 5 cycles per fetch
    loadDirected();
    i_fix = 5;
    d_fix = 0;
    doReset();
    applyStimulus(20, 600);
    checkOutput("stall_pc", 32'(current_pc), 32'h26);
    checkOutput("stall_halted", 32'(halted), 1);
    checkHaltQuiet();

    resetAbort();

    // Random programs with random wait states
    for (int p = 0; p < 3; p++) begin
      loadRandom();
      i_fix = -1;
      d_fix = -1;
      doReset();
      applyStimulus(250, 5000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
